// File: rtl/tree_image_loader.sv
// Decision-tree image loader: streams header, node/child words and checksum
// into the node and child SRAMs, validating pointers before the walk runs.
module tree_image_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned COEFF_W = 32,
  parameter int unsigned CHILD_W = 18,
  parameter logic [7:0] MAGIC = 8'hB5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [31:0]        s_data,
  output logic               node_we,
  output logic [ADDR_W-1:0]  node_addr,
  output logic [COEFF_W-1:0] node_wdata,
  output logic               child_we,
  output logic [ADDR_W-1:0]  child_addr,
  output logic [CHILD_W-1:0] child_wdata,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         err_code,
  output logic [ADDR_W:0]    nodes_loaded
);

  typedef enum logic [2:0] {
    IDLE, HDR, COEFF, CHILD, CHK, DONE, ERR
  } state_t;

  localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] NMAX = {1'b1, {ADDR_W{1'b0}}};

  state_t             state_q, state_d;
  logic [ADDR_W:0]    n_q;
  logic [ADDR_W-1:0]  idx_q;
  logic [31:0]        csum_q;

  logic               beat;
  logic [ADDR_W:0]    n_in, pa, pb, idx_x, n_m1;
  logic               hdr_ok, ok_a, ok_b, child_ok, last;
  logic               idle_like;

  assign beat  = s_valid && s_ready;
  assign n_in  = s_data[ADDR_W:0];
  assign hdr_ok = (s_data[31:24] == MAGIC) &&
                  (n_in != '0) && (n_in <= NMAX);

  // Non-class fields must point inside the tree and never to themselves
  assign idx_x = {1'b0, idx_q};
  assign pa    = (ADDR_W+1)'(s_data[16:9]);
  assign pb    = (ADDR_W+1)'(s_data[7:0]);
  assign ok_a  = s_data[17] || ((pa < n_q) && (pa != idx_x));
  assign ok_b  = s_data[8]  || ((pb < n_q) && (pb != idx_x));
  assign child_ok = ok_a && ok_b && (s_data[31:CHILD_W] == '0);
  assign n_m1  = n_q - ONE;
  assign last  = (idx_x == n_m1);
  assign idle_like = (state_q == IDLE) || (state_q == DONE) ||
                     (state_q == ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE, ERR: if (start) state_d = HDR;
      HDR:   if (beat) state_d = hdr_ok ? COEFF : ERR;
      COEFF: if (beat) state_d = CHILD;
      CHILD: if (beat) state_d = !child_ok ? ERR :
                                 last ? CHK : COEFF;
      CHK:   if (beat) state_d = (s_data == csum_q) ? DONE : ERR;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    unique case (1'b1)
      state_q == HDR,
      state_q == COEFF,
      state_q == CHILD,
      state_q == CHK: busy = 1'b1;
      default:        busy = 1'b0;
    endcase
    s_ready = busy;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q          <= '0;
      idx_q        <= '0;
      csum_q       <= '0;
      node_we      <= 1'b0;
      node_addr    <= '0;
      node_wdata   <= '0;
      child_we     <= 1'b0;
      child_addr   <= '0;
      child_wdata  <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_code     <= 2'b00;
      nodes_loaded <= '0;
    end else begin
      node_we  <= 1'b0;
      child_we <= 1'b0;
      if (idle_like && start) begin
        done         <= 1'b0;
        err          <= 1'b0;
        err_code     <= 2'b00;
        nodes_loaded <= '0;
        csum_q       <= '0;
        idx_q        <= '0;
      end
      if (beat) begin
        unique case (state_q)
          HDR: begin
            if (hdr_ok) begin
              n_q    <= n_in;
              csum_q <= csum_q ^ s_data;
            end else begin
              err      <= 1'b1;
              err_code <= 2'b01;
            end
          end
          COEFF: begin
            node_we    <= 1'b1;
            node_addr  <= idx_q;
            node_wdata <= s_data[COEFF_W-1:0];
            csum_q     <= csum_q ^ s_data;
          end
          CHILD: begin
            if (child_ok) begin
              child_we     <= 1'b1;
              child_addr   <= idx_q;
              child_wdata  <= s_data[CHILD_W-1:0];
              nodes_loaded <= nodes_loaded + ONE;
              csum_q       <= csum_q ^ s_data;
              if (!last) idx_q <= idx_q + ADDR_W'(1);
            end else begin
              err      <= 1'b1;
              err_code <= 2'b10;
            end
          end
          CHK: begin
            if (s_data == csum_q) begin
              done <= 1'b1;
            end else begin
              err      <= 1'b1;
              err_code <= 2'b11;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/tree_image_loader.md
Name: tree_image_loader

Overview:
- Writer side of the decision-tree node/child memories; the tree-walk engine is the reader.
- Accepts a tree image as a stream of 32-bit words over a valid/ready handshake.
- Writes each node's coefficient word into the node SRAM and its child-pointer word into the child SRAM.
- Validates the header, every child pointer and a trailing XOR checksum, then signals done so the walk engine may run.

Parameters:
- ADDR_W, 8, node address width; max nodes = 2**ADDR_W.
- COEFF_W, 32, node SRAM data width (four packed 8-bit coefficients/threshold).
- CHILD_W, 18, child SRAM data width (two 9-bit child fields; bit 8 of each field = class flag).
- MAGIC, 8'hB5, required header tag.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse, begins a load.
- s_valid  in  1  stream word valid.
- s_ready  out  1  loader can accept a word.
- s_data  in  32  stream word.
- node_we  out  1  node SRAM write strobe.
- node_addr  out  ADDR_W  node SRAM address.
- node_wdata  out  COEFF_W  node SRAM write data.
- child_we  out  1  child SRAM write strobe.
- child_addr  out  ADDR_W  child SRAM address.
- child_wdata  out  CHILD_W  child SRAM write data.
- busy  out  1  load in progress; walk engine must stay idle.
- done  out  1  image loaded and verified; level, held.
- err  out  1  load aborted; level, held.
- err_code  out  2  01 bad header, 10 bad child pointer, 11 checksum mismatch.
- nodes_loaded  out  ADDR_W+1  count of nodes fully written (coeff + child).

Behaviour:
- Reset: all outputs 0; state IDLE; checksum register 0.
- Beat: a word transfers when s_valid && s_ready. s_ready = 1 only in HDR, COEFF, CHILD and CHK; it is combinational from state.
- IDLE/DONE/ERR + start -> HDR. Entry clears done, err, err_code, nodes_loaded and checksum, and zeros the node index. start is ignored while busy.
- busy = 1 in HDR, COEFF, CHILD, CHK.
- HDR, on beat:
  - Field layout: s_data[31:24] = MAGIC; s_data[ADDR_W:0] = N, with 1 <= N <= 2**ADDR_W.
  - On violation -> ERR, code 01.
  - Otherwise latch N -> COEFF.
- COEFF, on beat:
  - Next cycle: node_we = 1 for exactly one cycle, node_addr = index, node_wdata = s_data.
  - -> CHILD.
- CHILD, on beat, each field F (s_data[17:9] and s_data[8:0]) is checked:
  - F[8] = 1: class leaf, always legal.
  - F[8] = 0: F[7:0] must be < N and must not equal the current index (no self-loop).
  - Any violation, or s_data[31:18] != 0 -> ERR, code 10. No child write on that beat.
  - Otherwise: next cycle child_we pulse, child_addr = index, child_wdata = s_data[17:0]; nodes_loaded increments.
  - If index == N-1 -> CHK, else index+1 -> COEFF.
- Checksum: XOR of the header word and every accepted COEFF/CHILD word.
- CHK, on beat: s_data == checksum -> DONE (done = 1 next cycle); else -> ERR, code 11.
- Write-port latency: exactly 1 cycle from beat to strobe. Strobes never both high in the same cycle.
- With s_valid held high: 2 cycles per node, 2N+2 beats in total.
- s_valid low stalls in any state indefinitely; no timeout.
- Abort: SRAM contents already written are not rolled back; err and err_code hold until the next start.
- N = 2**ADDR_W: index reaches all-ones without wrap; nodes_loaded reaches 2**ADDR_W (hence width ADDR_W+1).
- rst_n asserted mid-load: immediate return to IDLE. Any pending write strobe is dropped; outputs are 0.

Test Plan:
- Normal load: N=3, header 0xB5000003, nodes {C0,K0},{C1,K1},{C2,K2} with K0=0x00401 (children node1 and node2 pointers legal), K1/K2 leaves 0x3_0300, correct XOR.
  -> 3 node_we and 3 child_we pulses at addr 0,1,2; done=1; nodes_loaded=3; err=0.
- Bad header: header 0xA5000003 -> err=1, err_code=01, s_ready=0, no write strobes. Then start plus a valid image -> clean done.
- Bad child: N=2, node0 child word with field [8:0]=0x005 (non-class, index 5 >= 2).
  -> node_we at addr 0 only, no child_we, err_code=10, nodes_loaded=0.
- Checksum: valid N=1 image, final word = expected^1 -> both writes occur, err_code=11, done=0.
- Backpressure/stall: s_valid toggled 1,0,0,1,... through a N=2 load -> same SRAM writes and done as the unstalled load; no duplicate strobes.
- Reset mid-load: rst_n low after first COEFF beat, node_we pending -> strobe suppressed, all outputs 0.
  After release: start with N=2**ADDR_W full image -> nodes_loaded=256, done=1.
